// File: rtl/sseg_scan_decoder.sv
// rtl/sseg_scan_decoder.sv - recovers hex digits from a multiplexed 4-digit seven-segment scan bus
// Define SSEG_SCAN_DECODER_DP_EN to capture and publish per-digit decimal points.
module sseg_scan_decoder #(
  parameter int SETTLE_CYC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  sseg,
  input  logic [3:0]  an,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic [3:0]  blank,
  output logic        frame_valid,
  output logic        err
);

  localparam logic [7:0] SETTLE_N = 8'(SETTLE_CYC);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

  state_t      r_state;
  logic [6:0]  r_seg;
  logic [3:0]  r_an;
  logic [3:0]  r_cur;
  logic [7:0]  r_cnt;
  logic [3:0]  r_seen;
  logic [15:0] r_sh_val;
  logic [3:0]  r_sh_blank;

  logic        w_onehot;
  logic [1:0]  w_idx;
  logic        w_reeval;
  logic        w_load;
  logic        w_sample;
  logic        w_bad_an;
  logic        w_publish;
  logic [3:0]  w_nib;
  logic        w_dec_blank;
  logic        w_dec_bad;

  always_comb begin
    w_onehot = 1'b1;
    w_idx    = 2'd0;
    case (r_an)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_onehot = 1'b0;
    endcase
  end

  always_comb begin
    w_nib       = 4'h0;
    w_dec_blank = 1'b0;
    w_dec_bad   = 1'b0;
    case (r_seg)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      7'h7F: w_dec_blank = 1'b1;
      default: begin
        w_nib     = 4'hF;
        w_dec_bad = 1'b1;
      end
    endcase
  end

  // The load cycle is the first stable cycle, so the counter starts at 1 after loading.
  assign w_reeval  = (r_state == ST_IDLE) || (r_an != r_cur);
  assign w_load    = w_reeval && w_onehot;
  assign w_sample  = (w_load && (SETTLE_N == 8'd1)) ||
                     (!w_reeval && (r_state == ST_SETTLE) && ((r_cnt + 8'd1) == SETTLE_N));
  assign w_bad_an  = w_reeval && !w_onehot && (r_an != 4'hF);
  assign w_publish = (r_seen == 4'hF);

`ifdef SSEG_SCAN_DECODER_DP_EN
  logic       r_dp_in;
  logic [3:0] r_sh_dp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dp_in <= 1'b0;
      r_sh_dp <= 4'h0;
      dp      <= 4'h0;
    end else begin
      r_dp_in <= ~sseg[7];
      if (w_sample) r_sh_dp[w_idx] <= r_dp_in;
      if (w_publish) dp <= r_sh_dp;
    end
  end
`else
  logic w_unused_dp;
  assign w_unused_dp = sseg[7];
  assign dp          = 4'h0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_seg       <= 7'h00;
      r_an        <= 4'hF;
      r_cur       <= 4'hF;
      r_cnt       <= 8'd0;
      r_seen      <= 4'h0;
      r_sh_val    <= 16'h0000;
      r_sh_blank  <= 4'h0;
      value       <= 16'h0000;
      blank       <= 4'h0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      r_seg       <= sseg[6:0];
      r_an        <= an;
      frame_valid <= w_publish;

      if (w_reeval) begin
        if (w_onehot) begin
          r_cur   <= r_an;
          r_cnt   <= 8'd1;
          r_state <= w_sample ? ST_HOLD : ST_SETTLE;
        end else begin
          r_state <= ST_IDLE;
          r_cnt   <= 8'd0;
        end
      end else if (r_state == ST_SETTLE) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_sample) r_state <= ST_HOLD;
      end

      if (w_sample) begin
        r_sh_val[{w_idx, 2'b00} +: 4] <= w_nib;
        r_sh_blank[w_idx]             <= w_dec_blank;
      end

      // A sample landing on the publish cycle belongs to the next frame.
      r_seen <= (w_publish ? 4'h0 : r_seen) | (w_sample ? ~r_an : 4'h0);

      if (w_publish) begin
        value <= r_sh_val;
        blank <= r_sh_blank;
      end

      if (w_bad_an || (w_sample && w_dec_bad)) err <= 1'b1;
    end
  end

endmodule
